// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_TRAP
  } state_e;

  // Ordered by priority so a numeric compare ranks redirects.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JUMP,
    RD_TRAP
  } rd_kind_e;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_EXT      = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'd2;

  // A new redirect replaces a latched one unless the latched one outranks it.
  function automatic logic rd_wins(input rd_kind_e new_k, input rd_kind_e old_k);
    return (new_k != RD_NONE) && (new_k >= old_k);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Fetch/redirect bus between the sequencer, PC register, imem and execute logic.
interface pc_seq_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import pc_seq_pkg::*;

  logic [ADDR_W-1:0]  address;
  logic [ADDR_W-1:0]  next_address;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_target;
  logic               trap_req;
  logic               instr_valid;
  logic [ADDR_W-1:0]  epc;
  logic [CAUSE_W-1:0] trap_cause;

  modport master (
    input  address, imem_ready, stall, branch_taken, branch_target,
           jump_en, jump_target, trap_req,
    output next_address, imem_req, imem_addr, instr_valid, epc, trap_cause
  );

  modport slave (
    output address, imem_ready, stall, branch_taken, branch_target,
           jump_en, jump_target, trap_req,
    input  next_address, imem_req, imem_addr, instr_valid, epc, trap_cause
  );

endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational priority select of redirect kind/target (trap > jump > branch).
// PC_SEQ_MISALIGN_TRAP_EN: flag misaligned targets instead of clearing bits [1:0].
module pc_redirect_sel
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              trap_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output rd_kind_e          kind_c_o,
  output logic [ADDR_W-1:0] target_c_o,
  output logic              misalign_c_o
);

  always_comb begin
    kind_c_o   = RD_NONE;
    target_c_o = '0;
    if (trap_i) begin
      kind_c_o = RD_TRAP;
    end else if (jump_en_i) begin
      kind_c_o   = RD_JUMP;
      target_c_o = jump_target_i;
    end else if (branch_taken_i) begin
      kind_c_o   = RD_BRANCH;
      target_c_o = branch_target_i;
    end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    misalign_c_o = (target_c_o[1:0] != 2'b00);
`else
    misalign_c_o     = 1'b0;
    target_c_o[1:0]  = 2'b00;
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot vector, fetch handshake, redirect buffering, trap entry.
// Misaligned-target traps are enabled with PC_SEQ_MISALIGN_TRAP_EN (see pc_redirect_sel).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(32'h0000_0100),
  parameter int unsigned       INSTR_BYTES  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_seq_if.master bus
);

  state_e               state_q, state_d;
  logic                 pend_valid_q, pend_valid_d;
  rd_kind_e             pend_kind_q, pend_kind_d;
  logic [ADDR_W-1:0]    pend_target_q, pend_target_d;
  logic [ADDR_W-1:0]    epc_q, epc_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;

  rd_kind_e             sel_kind_c;
  logic [ADDR_W-1:0]    sel_target_c;
  logic                 sel_misalign_c;
  logic                 pend_misalign_c;
  logic [ADDR_W-1:0]    next_addr_c;
  logic                 imem_req_c;
  logic                 instr_valid_c;

  // One selector feeds both the live redirect and the pending-latch update.
  pc_redirect_sel #(.ADDR_W(ADDR_W)) u_sel (
    .trap_i          (bus.trap_req),
    .jump_en_i       (bus.jump_en),
    .jump_target_i   (bus.jump_target),
    .branch_taken_i  (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .kind_c_o        (sel_kind_c),
    .target_c_o      (sel_target_c),
    .misalign_c_o    (sel_misalign_c)
  );

  // Low bits are only ever non-zero when the misalign trap feature is built in.
  assign pend_misalign_c = (pend_kind_q != RD_TRAP) && (pend_target_q[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pend_valid_q  <= 1'b0;
      pend_kind_q   <= RD_NONE;
      pend_target_q <= '0;
      epc_q         <= '0;
      cause_q       <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_kind_q   <= pend_kind_d;
      pend_target_q <= pend_target_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_kind_d   = pend_kind_q;
    pend_target_d = pend_target_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    next_addr_c   = bus.address;
    imem_req_c    = 1'b0;
    instr_valid_c = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        next_addr_c = RESET_VECTOR;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        next_addr_c = TRAP_VECTOR;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (!bus.imem_ready) begin
          if (rd_wins(sel_kind_c, pend_kind_q)) begin
            pend_valid_d  = 1'b1;
            pend_kind_d   = sel_kind_c;
            pend_target_d = sel_target_c;
          end
        end else if (pend_valid_q) begin
          // Fetched word is on the wrong path: drop it and apply the redirect.
          pend_valid_d = 1'b0;
          pend_kind_d  = RD_NONE;
          if (pend_kind_q == RD_TRAP || pend_misalign_c) begin
            epc_d   = bus.address;
            cause_d = (pend_kind_q == RD_TRAP) ? CAUSE_EXT : CAUSE_MISALIGN;
            state_d = S_TRAP;
          end else begin
            next_addr_c = pend_target_q;
          end
        end else if (!bus.stall) begin
          instr_valid_c = 1'b1;
          if (sel_kind_c == RD_TRAP || sel_misalign_c) begin
            epc_d   = bus.address;
            cause_d = (sel_kind_c == RD_TRAP) ? CAUSE_EXT : CAUSE_MISALIGN;
            state_d = S_TRAP;
          end else if (sel_kind_c != RD_NONE) begin
            next_addr_c = sel_target_c;
          end else begin
            next_addr_c = bus.address + ADDR_W'(INSTR_BYTES);
          end
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign bus.next_address = next_addr_c;
  assign bus.imem_req     = imem_req_c;
  assign bus.imem_addr    = bus.address;
  assign bus.instr_valid  = instr_valid_c;
  assign bus.epc          = epc_q;
  assign bus.trap_cause   = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a local PC register model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int unsigned ADDR_W       = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_q;
  int          checks   = 0;
  int          failures = 0;

  pc_seq_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR),
    .INSTR_BYTES  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // PC register: loads next_address every cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_VECTOR;
    else        pc_q <= bus.next_address;
  end
  assign bus.address = pc_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imem_ready   = 1'b1;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump_en      = 1'b0;
    bus.trap_req     = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    bus.jump_en     = 1'b1;
    bus.jump_target = tgt;
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    bus.branch_target = '0;
    bus.jump_target   = '0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_next",  bus.next_address, RESET_VECTOR);
    check_eq("rst_req",   32'(bus.imem_req), 32'd0);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_epc",   bus.epc, 32'h0);
    check_eq("rst_cause", 32'(bus.trap_cause), 32'd0);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_eq("boot_next", bus.next_address, RESET_VECTOR);
    check_eq("boot_req",  32'(bus.imem_req), 32'd0);

    // Sequential fetch 0,4,8
    tick(); #1;
    check_eq("f0_req",   32'(bus.imem_req), 32'd1);
    check_eq("f0_addr",  bus.imem_addr, 32'h0);
    check_eq("f0_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("f0_next",  bus.next_address, 32'h4);
    tick(); #1;
    check_eq("f4_next",  bus.next_address, 32'h8);
    tick();

    // Branch arrives while imem is not ready: buffered, wrong-path word discarded
    bus.imem_ready = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 32'h40; #1;
    check_eq("nr1_next",  bus.next_address, 32'h8);
    check_eq("nr1_valid", 32'(bus.instr_valid), 32'd0);
    tick(); bus.branch_taken = 1'b0; #1;
    check_eq("nr2_next",  bus.next_address, 32'h8);
    tick(); #1;
    check_eq("nr3_addr",  bus.imem_addr, 32'h8);
    tick(); bus.imem_ready = 1'b1; #1;
    check_eq("rdy_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rdy_next",  bus.next_address, 32'h40);
    tick(); #1;
    check_eq("br_addr",   bus.imem_addr, 32'h40);
    check_eq("br_next",   bus.next_address, 32'h44);

    // Jump beats branch in the same cycle
    bus.jump_en = 1'b1; bus.jump_target = 32'h200;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h80; #1;
    check_eq("jmp_pri",   bus.next_address, 32'h200);
    tick(); idle();

    // External trap at 0x1C
    jump_to(32'h1C);
    bus.trap_req = 1'b1; #1;
    check_eq("trap_hold",  bus.next_address, 32'h1C);
    check_eq("trap_valid", 32'(bus.instr_valid), 32'd1);
    tick(); bus.trap_req = 1'b0; #1;
    check_eq("trap_epc",   bus.epc, 32'h1C);
    check_eq("trap_cause", 32'(bus.trap_cause), 32'd1);
    check_eq("trap_req",   32'(bus.imem_req), 32'd0);
    check_eq("trap_iv",    32'(bus.instr_valid), 32'd0);
    check_eq("trap_next",  bus.next_address, TRAP_VECTOR);
    tick(); #1;
    check_eq("hdl_addr",   bus.imem_addr, 32'h100);
    check_eq("hdl_next",   bus.next_address, 32'h104);
    tick();

    // Stall holds PC and ignores the branch
    jump_to(32'h10);
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80; #1;
    check_eq("st1_next",  bus.next_address, 32'h10);
    check_eq("st1_valid", 32'(bus.instr_valid), 32'd0);
    tick(); #1;
    check_eq("st2_next",  bus.next_address, 32'h10);
    tick(); idle(); #1;
    check_eq("st_done",   bus.next_address, 32'h14);
    check_eq("st_valid",  32'(bus.instr_valid), 32'd1);
    tick();

    // Address wrap, then misaligned branch target
    jump_to(32'hFFFF_FFFC); #1;
    check_eq("wrap_next", bus.next_address, 32'h0);
    tick();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h42; #1;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    check_eq("mis_hold",  bus.next_address, 32'h0);
    tick(); idle(); #1;
    check_eq("mis_cause", 32'(bus.trap_cause), 32'd2);
    check_eq("mis_epc",   bus.epc, 32'h0);
    check_eq("mis_next",  bus.next_address, TRAP_VECTOR);
`else
    check_eq("mis_next",  bus.next_address, 32'h40);
    tick(); idle(); #1;
    check_eq("mis_cause", 32'(bus.trap_cause), 32'd1);
    check_eq("mis_epc",   bus.epc, 32'h1C);
`endif
    tick();

    // Latched jump is not overwritten by a later branch
    jump_to(32'h500);
    bus.imem_ready = 1'b0; bus.jump_en = 1'b1; bus.jump_target = 32'h300; #1;
    check_eq("pj_hold",  bus.next_address, 32'h500);
    tick(); bus.jump_en = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
    tick(); bus.branch_taken = 1'b0; bus.imem_ready = 1'b1; #1;
    check_eq("pj_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("pj_next",  bus.next_address, 32'h300);
    tick();

    // Later trap overwrites a latched jump
    bus.imem_ready = 1'b0; bus.jump_en = 1'b1; bus.jump_target = 32'h600;
    tick(); bus.jump_en = 1'b0; bus.trap_req = 1'b1;
    tick(); bus.trap_req = 1'b0; bus.imem_ready = 1'b1; #1;
    check_eq("pt_hold",  bus.next_address, 32'h300);
    check_eq("pt_valid", 32'(bus.instr_valid), 32'd0);
    tick(); #1;
    check_eq("pt_epc",   bus.epc, 32'h300);
    check_eq("pt_cause", 32'(bus.trap_cause), 32'd1);
    check_eq("pt_next",  bus.next_address, TRAP_VECTOR);
    tick();

    // Reset mid-fetch drops the pending redirect
    bus.imem_ready = 1'b0; bus.jump_en = 1'b1; bus.jump_target = 32'h700;
    tick(); idle();
    rst_n = 1'b0; #1;
    check_eq("mr_next",  bus.next_address, RESET_VECTOR);
    check_eq("mr_req",   32'(bus.imem_req), 32'd0);
    check_eq("mr_epc",   bus.epc, 32'h0);
    check_eq("mr_cause", 32'(bus.trap_cause), 32'd0);
    tick(); rst_n = 1'b1; #1;
    check_eq("mr_boot",  bus.next_address, RESET_VECTOR);
    tick(); #1;
    check_eq("mr_f0",    bus.next_address, 32'h4);
    check_eq("mr_valid", 32'(bus.instr_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
